// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared widths, the fetch queue entry type and the fetch
//                stage state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   localparam int XLEN       = 32;
   localparam int INSN_BYTES = 4;

   // One delivered instruction: its byte address and the word memory returned
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   // Explicit 1-bit encoding; FAULT is sticky until redirect or reset
   typedef enum logic [0:0] {
      RUN   = 1'b0,
      FAULT = 1'b1
   } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Two-entry synchronous FIFO of fetch entries. Slot 0 is always
//                the head, so when the queue empties the head keeps showing
//                the last delivered entry. Flush wins over push and pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
   import cpu_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   output fetch_entry_t head,
   output logic [1:0]   count
);

   fetch_entry_t r_slot [2];
   logic [1:0]   r_count;
   logic         w_pop_ok;
   logic         w_push_ok;

   assign w_pop_ok  = pop && (r_count != 2'd0);
   assign w_push_ok = push && ((r_count != 2'd2) || w_pop_ok);

   // Queue storage and occupancy; entries shift toward slot 0 on pop
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count   <= 2'd0;
         r_slot[0] <= '0;
         r_slot[1] <= '0;
      end else if (flush) begin
         r_count <= 2'd0;
      end else begin
         case ({w_push_ok, w_pop_ok})
            2'b10: begin
               if (r_count == 2'd0) r_slot[0] <= push_data;
               else                 r_slot[1] <= push_data;
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               if (r_count == 2'd2) r_slot[0] <= r_slot[1];
               r_count <= r_count - 2'd1;
            end
            2'b11: begin
               if (r_count == 2'd2) begin
                  r_slot[0] <= r_slot[1];
                  r_slot[1] <= push_data;
               end else begin
                  r_slot[0] <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign head  = r_slot[0];
   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/ifetch.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch
//  Description : Instruction fetch stage. Owns the PC, issues one read per
//                cycle to a 1-cycle-latency instruction memory, captures the
//                returned word into a 2-entry queue toward decode, handles
//                branch redirects and flags misaligned / out-of-range PCs.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifetch
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          MEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   output logic        imem_we,
   output logic [31:0] imem_wdata,
   input  logic [31:0] imem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        fault
);

   localparam logic [32:0] c_mem_limit = 33'(MEM_BYTES);

   logic [31:0]  r_pc;
   logic [31:0]  r_issued_pc;
   logic         r_inflight;
   fetch_state_e r_state;
   fetch_state_e w_state_nxt;

   logic [32:0]  w_last_byte;
   logic         w_bad_pc;
   logic         w_pop;
   logic         w_push;
   logic         w_issue;
   logic [2:0]   w_occupancy;
   logic [1:0]   w_count;
   fetch_entry_t w_head;
   fetch_entry_t w_push_data;

   // 33-bit sum so a PC near the top of the address space cannot wrap into range
   assign w_last_byte = {1'b0, r_pc} + 33'd3;
   assign w_bad_pc    = (r_pc[1:0] != 2'b00) || (w_last_byte >= c_mem_limit);

   assign out_valid   = (w_count != 2'd0);
   assign w_pop       = out_valid && out_ready;

   // Slots already owed to the queue after this cycle's pop must leave room for one more
   assign w_occupancy = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_issue     = (r_state == RUN) && !w_bad_pc && (w_occupancy < 3'd2) && !redirect_valid;

   // A redirect kills the word returning this cycle
   assign w_push      = r_inflight && !redirect_valid;
   assign w_push_data = '{pc: r_issued_pc, instr: imem_rdata};

   fetch_queue u_queue (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (w_push),
      .push_data (w_push_data),
      .pop       (w_pop),
      .head      (w_head),
      .count     (w_count)
   );

   // PC, issued-address and in-flight tracking; redirect overrides issue
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc        <= RESET_PC;
         r_issued_pc <= '0;
         r_inflight  <= 1'b0;
      end else if (redirect_valid) begin
         r_pc       <= redirect_pc;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_issued_pc <= r_pc;
            r_pc        <= r_pc + 32'(INSN_BYTES);
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= RUN;
      else     r_state <= w_state_nxt;
   end

   // FSM next state: a bad PC while running faults, only a redirect recovers
   always_comb begin
      w_state_nxt = r_state;
      if (redirect_valid)
         w_state_nxt = RUN;
      else if ((r_state == RUN) && w_bad_pc)
         w_state_nxt = FAULT;
   end

   // FSM outputs
   always_comb begin
      fault = (r_state == FAULT);
   end

   assign imem_addr  = r_pc;
   assign imem_we    = 1'b0;
   assign imem_wdata = 32'h0000_0000;
   assign out_pc     = w_head.pc;
   assign out_instr  = w_head.instr;

endmodule
`default_nettype wire

// File: tb/tb_ifetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifetch
//  Description : Directed self-checking bench for ifetch with a behavioural
//                1-cycle instruction memory and an expected-delivery queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic        imem_we;
   logic [31:0] imem_wdata;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        fault;

   int n_checks = 0;
   int n_errors = 0;
   int hs_count = 0;

   fetch_entry_t exp_q [$];
   logic [31:0]  mem [0:255];

   always #5 clk = ~clk;

   ifetch #(.RESET_PC(32'h0000_0000), .MEM_BYTES(1024)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_addr      (imem_addr),
      .imem_we        (imem_we),
      .imem_wdata     (imem_wdata),
      .imem_rdata     (imem_rdata),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .fault          (fault)
   );

   // Memory contents as a function of byte address
   function automatic logic [31:0] word_at(input logic [31:0] a);
      if (a == 32'h0)      return 32'hAABB_CCDD;
      else if (a == 32'h4) return 32'h1122_3344;
      else                 return {16'hC0DE, a[15:0]};
   endfunction

   // Synchronous-read instruction memory
   always @(posedge clk) imem_rdata <= mem[imem_addr[9:2]];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_pc(input logic [31:0] a);
      fetch_entry_t e;
      e.pc    = a;
      e.instr = word_at(a);
      exp_q.push_back(e);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Hold out_ready high until n more handshakes have completed
   task automatic consume(input int n);
      int target = hs_count + n;
      int k = 0;
      out_ready = 1'b1;
      while (hs_count < target && k < 40) begin
         cyc();
         k++;
      end
      out_ready = 1'b0;
      n_checks++;
      assert (hs_count == target) else begin
         n_errors++;
         $error("FAIL consume_timeout: observed %0d handshakes expected %0d", hs_count, target);
      end
   endtask

   task automatic do_redirect(input logic [31:0] a);
      redirect_valid = 1'b1;
      redirect_pc    = a;
      cyc();
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
   endtask

   // Scoreboard: every handshake must match the oldest expected entry
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         n_checks++;
         assert (exp_q.size() != 0) else begin
            n_errors++;
            $error("FAIL extra_out: observed pc %h, expected no delivery", out_pc);
         end
         if (exp_q.size() != 0) begin
            fetch_entry_t e;
            e = exp_q.pop_front();
            chk("sb_pc", out_pc, e.pc);
            chk("sb_instr", out_instr, e.instr);
         end
         hs_count++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish expected finish before 100us");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = word_at(32'(i * 4));
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      out_ready      = 1'b0;
      repeat (3) cyc();

      // Reset state
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_pc", out_pc, 32'h0);
      chk("rst_instr", out_instr, 32'h0);
      chk("rst_fault", {31'b0, fault}, 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("we_tied", {31'b0, imem_we}, 32'd0);
      chk("wdata_tied", imem_wdata, 32'h0);

      // 1: first delivery two cycles after reset release
      expect_pc(32'h0);
      expect_pc(32'h4);
      rst       = 1'b0;
      out_ready = 1'b1;
      cyc();
      chk("t1_valid_c1", {31'b0, out_valid}, 32'd0);
      cyc();
      chk("t1_valid_c2", {31'b0, out_valid}, 32'd1);
      chk("t1_pc_c2", out_pc, 32'h0);
      chk("t1_instr_c2", out_instr, 32'hAABB_CCDD);
      consume(2);

      // 2: stall, queue saturates holding 8 and 12, PC parks at 16
      repeat (6) cyc();
      chk("t2_addr", imem_addr, 32'd16);
      chk("t2_valid", {31'b0, out_valid}, 32'd1);
      chk("t2_head", out_pc, 32'd8);
      expect_pc(32'd8);
      expect_pc(32'd12);
      expect_pc(32'd16);
      consume(3);
      repeat (3) cyc();

      // 3: redirect with queue occupied and a read in flight
      expect_pc(32'd20);
      consume(1);
      do_redirect(32'h40);
      chk("t3_flushed", {31'b0, out_valid}, 32'd0);
      chk("t3_addr", imem_addr, 32'h40);
      expect_pc(32'h40);
      expect_pc(32'h44);
      consume(2);

      // 4: last word in range, then fault at 0x400
      do_redirect(32'h3FC);
      cyc();
      chk("t4_fault_c1", {31'b0, fault}, 32'd0);
      cyc();
      chk("t4_fault_c2", {31'b0, fault}, 32'd1);
      chk("t4_head", out_pc, 32'h3FC);
      chk("t4_instr", out_instr, word_at(32'h3FC));
      chk("t4_addr", imem_addr, 32'h400);
      repeat (2) cyc();
      chk("t4_addr_hold", imem_addr, 32'h400);
      expect_pc(32'h3FC);
      consume(1);
      repeat (3) cyc();
      chk("t4_drained", {31'b0, out_valid}, 32'd0);
      chk("t4_fault_sticky", {31'b0, fault}, 32'd1);
      chk("t4_pc_hold", out_pc, 32'h3FC);

      // 5: misaligned redirect faults; aligned redirect recovers
      out_ready = 1'b1;
      do_redirect(32'h102);
      chk("t5_fault_clr", {31'b0, fault}, 32'd0);
      cyc();
      chk("t5_fault_set", {31'b0, fault}, 32'd1);
      repeat (3) cyc();
      chk("t5_no_valid", {31'b0, out_valid}, 32'd0);
      chk("t5_addr", imem_addr, 32'h102);
      out_ready = 1'b0;
      do_redirect(32'h100);
      chk("t5_recover", {31'b0, fault}, 32'd0);
      cyc();
      chk("t5_valid_c1", {31'b0, out_valid}, 32'd0);
      cyc();
      chk("t5_valid_c2", {31'b0, out_valid}, 32'd1);
      chk("t5_pc", out_pc, 32'h100);
      expect_pc(32'h100);
      consume(1);

      // 6: reset pulse while queue occupied and a read in flight
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("t6_valid", {31'b0, out_valid}, 32'd0);
      chk("t6_fault", {31'b0, fault}, 32'd0);
      chk("t6_addr", imem_addr, 32'h0);
      chk("t6_pc", out_pc, 32'h0);
      expect_pc(32'h0);
      expect_pc(32'h4);
      expect_pc(32'h8);
      consume(3);
      repeat (2) cyc();

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
